keypad_code_lock: RTL and testbench

KEYPAD_CODE_LOCK -- requirements
Module: keypad_code_lock

---
 rtl/keypad_code_lock.sv | 165 ++++++++++++++++
 tb/tb_keypad_code_lock.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/keypad_code_lock.sv
// Keypad code lock: digit entry, code check, timed open, code programming, lockout after repeated failures.
// Each key acts at its strobe edge; check result one edge after '#'; no backpressure, keys outside a listening state are dropped.
module keypad_code_lock #(
  parameter int                      CODE_LEN     = 4,
  parameter logic [4*CODE_LEN-1:0]   DEFAULT_CODE = 16'h1234,
  parameter int                      MAX_TRIES    = 3,
  parameter int                      OPEN_CYCLES  = 50_000_000,
  parameter int                      LOCK_CYCLES  = 500_000_000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_key_valid,
  input  logic [3:0] i_key,
  output logic       o_open,
  output logic       o_locked,
  output logic       o_err,
  output logic [2:0] o_state,
  output logic [2:0] o_count
);

  localparam int BW   = 4 * CODE_LEN;
  localparam int TMAX = (OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int FW   = $clog2(MAX_TRIES + 1);

  localparam logic [2:0]    CNT_FULL  = 3'(CODE_LEN);
  localparam logic [FW-1:0] FAIL_LAST = FW'(MAX_TRIES - 1);
  localparam logic [TW-1:0] OPEN_LOAD = TW'(OPEN_CYCLES - 1);
  localparam logic [TW-1:0] LOCK_LOAD = TW'(LOCK_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ENTRY   = 3'd1,
    CHECK   = 3'd2,
    OPEN    = 3'd3,
    PROGRAM = 3'd4,
    LOCKOUT = 3'd5
  } state_t;

  state_t        state_q, state_n;
  logic [BW-1:0] buf_q, buf_n, code_q, code_n, buf_shift;
  logic [2:0]    cnt_q, cnt_n;
  logic [FW-1:0] fail_q, fail_n;
  logic [TW-1:0] tmr_q, tmr_n;
  logic          err_q, err_n;
  logic          is_digit, is_star, is_hash, full;

  assign is_digit  = i_key_valid && (i_key <= 4'd9);
  assign is_star   = i_key_valid && (i_key == 4'd10);
  assign is_hash   = i_key_valid && (i_key == 4'd11);
  assign full      = (cnt_q == CNT_FULL);
  assign buf_shift = BW'({buf_q, i_key});

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      buf_q   <= '0;
      cnt_q   <= '0;
      fail_q  <= '0;
      tmr_q   <= '0;
      code_q  <= DEFAULT_CODE;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      buf_q   <= buf_n;
      cnt_q   <= cnt_n;
      fail_q  <= fail_n;
      tmr_q   <= tmr_n;
      code_q  <= code_n;
      err_q   <= err_n;
    end
  end

  always_comb begin
    state_n = state_q;
    buf_n   = buf_q;
    cnt_n   = cnt_q;
    fail_n  = fail_q;
    tmr_n   = tmr_q;
    code_n  = code_q;
    err_n   = 1'b0;

    // Digits saturate once the buffer holds a full code.
    if ((state_q == IDLE || state_q == ENTRY || state_q == PROGRAM) && is_digit && !full) begin
      buf_n = buf_shift;
      cnt_n = cnt_q + 3'd1;
    end

    case (state_q)
      IDLE: begin
        if (is_digit) state_n = ENTRY;
      end
      ENTRY: begin
        if (is_star) begin
          buf_n   = '0;
          cnt_n   = '0;
          state_n = IDLE;
        end else if (is_hash) begin
          state_n = CHECK;
        end
      end
      CHECK: begin
        buf_n = '0;
        cnt_n = '0;
        if (full && (buf_q == code_q)) begin
          fail_n  = '0;
          tmr_n   = OPEN_LOAD;
          state_n = OPEN;
        end else begin
          err_n  = 1'b1;
          fail_n = fail_q + FW'(1);
          if (fail_q >= FAIL_LAST) begin
            tmr_n   = LOCK_LOAD;
            state_n = LOCKOUT;
          end else begin
            state_n = IDLE;
          end
        end
      end
      OPEN: begin
        // Expiry takes priority over a '#' arriving on the last open cycle.
        if (tmr_q == '0) begin
          state_n = IDLE;
        end else begin
          tmr_n = tmr_q - TW'(1);
          if (is_hash) state_n = PROGRAM;
        end
      end
      PROGRAM: begin
        if (is_hash) begin
          buf_n = '0;
          cnt_n = '0;
          if (full) begin
            code_n  = buf_q;
            state_n = IDLE;
          end else begin
            err_n = 1'b1;
          end
        end else if (is_star) begin
          buf_n   = '0;
          cnt_n   = '0;
          state_n = IDLE;
        end
      end
      LOCKOUT: begin
        if (tmr_q == '0) begin
          fail_n  = '0;
          state_n = IDLE;
        end else begin
          tmr_n = tmr_q - TW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    o_state  = state_q;
    o_count  = cnt_q;
    o_open   = (state_q == OPEN);
    o_locked = (state_q == LOCKOUT);
    o_err    = err_q;
  end

endmodule

// File: tb/tb_keypad_code_lock.sv
// Scoreboard bench: each driven cycle pushes its hand-derived expected outputs, popped and checked #1 after the edge.
module tb_keypad_code_lock;

  localparam logic [2:0] S_IDLE = 3'd0, S_ENTRY = 3'd1, S_CHECK = 3'd2,
                         S_OPEN = 3'd3, S_PROG  = 3'd4, S_LOCK  = 3'd5;

  typedef struct packed {
    logic [2:0] st;
    logic [2:0] cnt;
    logic       err;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_valid = 1'b0;
  logic [3:0] key = 4'd0;
  logic       open, locked, err;
  logic [2:0] state, count;

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  keypad_code_lock #(
    .CODE_LEN    (4),
    .DEFAULT_CODE(16'h1234),
    .MAX_TRIES   (3),
    .OPEN_CYCLES (8),
    .LOCK_CYCLES (16)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_key_valid(key_valid),
    .i_key      (key),
    .o_open     (open),
    .o_locked   (locked),
    .o_err      (err),
    .o_state    (state),
    .o_count    (count)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic cyc(input bit v, input logic [3:0] k, input logic [2:0] st,
                     input logic [2:0] cnt, input bit e, input string tag);
    exp_t x;
    key_valid = v;
    key       = k;
    sb.push_back('{st: st, cnt: cnt, err: e});
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    x = sb.pop_front();
    check({tag, ".state"},  32'(state),  32'(x.st));
    check({tag, ".count"},  32'(count),  32'(x.cnt));
    check({tag, ".open"},   32'(open),   32'(x.st == S_OPEN));
    check({tag, ".locked"}, 32'(locked), 32'(x.st == S_LOCK));
    check({tag, ".err"},    32'(err),    32'(x.err));
  endtask

  task automatic press(input logic [3:0] k, input logic [2:0] st, input logic [2:0] cnt,
                       input bit e, input string tag);
    cyc(1'b1, k, st, cnt, e, tag);
  endtask

  task automatic idle(input int n, input logic [2:0] st, input string tag);
    for (int i = 0; i < n; i++) cyc(1'b0, 4'd0, st, 3'd0, 1'b0, tag);
  endtask

  task automatic digits4(input logic [15:0] c, input string tag);
    for (int i = 0; i < 4; i++) press(c[15-4*i -: 4], S_ENTRY, 3'(i + 1), 1'b0, tag);
    press(4'd11, S_CHECK, 3'd4, 1'b0, tag);
  endtask

  task automatic open_with(input logic [15:0] c, input string tag);
    digits4(c, tag);
    cyc(1'b0, 4'd0, S_OPEN, 3'd0, 1'b0, tag);
  endtask

  task automatic fail_with(input logic [15:0] c, input logic [2:0] after, input string tag);
    digits4(c, tag);
    cyc(1'b0, 4'd0, after, 3'd0, 1'b1, tag);
  endtask

  task automatic wait_open_out(input string tag);
    idle(7, S_OPEN, tag);
    idle(1, S_IDLE, tag);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    cyc(1'b0, 4'd0, S_IDLE, 3'd0, 1'b0, tag);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle(2, S_IDLE, "reset");
    rst = 1'b0;

    // Correct code: one CHECK cycle then exactly eight open cycles; digits and '*' ignored.
    open_with(16'h1234, "open1");
    press(4'd5,  S_OPEN, 3'd0, 1'b0, "open_dig");
    press(4'd10, S_OPEN, 3'd0, 1'b0, "open_star");
    press(4'd12, S_OPEN, 3'd0, 1'b0, "open_inv");
    idle(4, S_OPEN, "open_hold");
    idle(1, S_IDLE, "open_end");

    // Three failures lock out for 16 cycles, keys ignored, fail counter then cleared.
    fail_with(16'h9999, S_IDLE, "fail1");
    fail_with(16'h9999, S_IDLE, "fail2");
    fail_with(16'h9999, S_LOCK, "fail3");
    press(4'd1,  S_LOCK, 3'd0, 1'b0, "lock_k");
    press(4'd2,  S_LOCK, 3'd0, 1'b0, "lock_k");
    press(4'd3,  S_LOCK, 3'd0, 1'b0, "lock_k");
    press(4'd4,  S_LOCK, 3'd0, 1'b0, "lock_k");
    press(4'd11, S_LOCK, 3'd0, 1'b0, "lock_k");
    idle(10, S_LOCK, "lock_hold");
    idle(1, S_IDLE, "lock_end");
    fail_with(16'h9999, S_IDLE, "fail_after_lock");

    // Saturating entry, invalid keys, '*' clear.
    press(4'd12, S_IDLE, 3'd0, 1'b0, "idle_inv");
    press(4'd10, S_IDLE, 3'd0, 1'b0, "idle_star");
    press(4'd11, S_IDLE, 3'd0, 1'b0, "idle_hash");
    for (int i = 0; i < 4; i++) press(4'(i + 1), S_ENTRY, 3'(i + 1), 1'b0, "sat");
    press(4'd15, S_ENTRY, 3'd4, 1'b0, "sat_inv");
    press(4'd5,  S_ENTRY, 3'd4, 1'b0, "sat5");
    press(4'd6,  S_ENTRY, 3'd4, 1'b0, "sat6");
    press(4'd11, S_CHECK, 3'd4, 1'b0, "sat_hash");
    cyc(1'b0, 4'd0, S_OPEN, 3'd0, 1'b0, "sat_open");
    wait_open_out("sat_wait");
    press(4'd1,  S_ENTRY, 3'd1, 1'b0, "clr1");
    press(4'd2,  S_ENTRY, 3'd2, 1'b0, "clr2");
    press(4'd10, S_IDLE,  3'd0, 1'b0, "clr_star");
    open_with(16'h1234, "clr_open");

    // Programming: short entry rejected, then 5678 stored.
    press(4'd11, S_PROG, 3'd0, 1'b0, "prog_enter");
    press(4'd5,  S_PROG, 3'd1, 1'b0, "prog5");
    press(4'd6,  S_PROG, 3'd2, 1'b0, "prog6");
    press(4'd11, S_PROG, 3'd0, 1'b1, "prog_short");
    for (int i = 0; i < 4; i++) press(4'(i + 5), S_PROG, 3'(i + 1), 1'b0, "prog_dig");
    press(4'd11, S_IDLE, 3'd0, 1'b0, "prog_store");
    fail_with(16'h1234, S_IDLE, "old_code");
    open_with(16'h5678, "new_code");

    // '*' in PROGRAM abandons without changing the code.
    press(4'd11, S_PROG, 3'd0, 1'b0, "abort_enter");
    for (int i = 0; i < 4; i++) press(4'(i + 1), S_PROG, 3'(i + 1), 1'b0, "abort_dig");
    press(4'd10, S_IDLE, 3'd0, 1'b0, "abort_star");
    fail_with(16'h1234, S_IDLE, "abort_old");
    open_with(16'h5678, "abort_keep");

    // Reset during ENTRY restores the default code; reset during OPEN closes.
    wait_open_out("rst_wait");
    press(4'd1, S_ENTRY, 3'd1, 1'b0, "rst_e1");
    press(4'd2, S_ENTRY, 3'd2, 1'b0, "rst_e2");
    do_reset("rst_entry");
    open_with(16'h1234, "rst_default");
    do_reset("rst_open");

    // '#' on the last open cycle loses to expiry.
    open_with(16'h1234, "edge_open");
    idle(7, S_OPEN, "edge_hold");
    press(4'd11, S_IDLE, 3'd0, 1'b0, "edge_hash");
    press(4'd1,  S_ENTRY, 3'd1, 1'b0, "edge1");
    press(4'd2,  S_ENTRY, 3'd2, 1'b0, "edge2");
    press(4'd11, S_CHECK, 3'd2, 1'b0, "edge_chk");
    cyc(1'b0, 4'd0, S_IDLE, 3'd0, 1'b1, "edge_err");
    idle(1, S_IDLE, "edge_err_clr");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
